alu_fpga_seq: RTL

//  Board-level sequenced ALU test harness for the DE2 (50 MHz). Debounces the four push-buttons,

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/fpga_disp_pkg.sv | 49 ++++
 rtl/alu_fpga_seq_key_debounce.sv | 56 +++++
 rtl/alu_fpga_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU datapath types: the machine word and the ALU operation code that
// the datapath and the board harness both use.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int CPU_WORD_W = 32;

    typedef logic [CPU_WORD_W-1:0] word_t;

    // 4-bit ALU opcode; gaps in the encoding are reserved.
    typedef enum logic [3:0] {
        ALU_SLL  = 4'h0,
        ALU_SRL  = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SUB  = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_NOR  = 4'h7,
        ALU_SLT  = 4'hA,
        ALU_SLTU = 4'hB
    } aluop_t;

endpackage

// File: rtl/fpga_disp_pkg.sv
// -----------------------------------------------------------------------------
// fpga_disp_pkg
// Types and helpers for the DE2 ALU harness: display page selector, sequencer
// state, and the active-low 7-segment hex encoder.
// -----------------------------------------------------------------------------
package fpga_disp_pkg;

    typedef enum logic [1:0] {
        RESULT = 2'd0,
        OPA    = 2'd1,
        OPB    = 2'd2,
        STATUS = 2'd3
    } page_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        LATCH = 2'd2,
        SHOW  = 2'd3
    } seq_state_t;

    // All segments off (segments are active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Nibble to DE2 segment pattern, bit order {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/alu_fpga_seq_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises one raw active-low push-button and debounces it. The debounced
// level only changes after DEBOUNCE_CYCLES consecutive samples disagree with
// it, so presses and releases both need the full stable time, and any bounce
// restarts the count. One single-cycle pulse is emitted per accepted press.
//
// Ports
//   CLK    in   system clock
//   nRST   in   asynchronous active-low reset (key treated as released)
//   key_n  in   raw button, active-low, asynchronous to CLK
//   press  out  1-cycle pulse when a press is accepted
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic nRST,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;   // debounced key, 1 = released
    logic [CNT_W-1:0] cnt;     // consecutive samples differing from level

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the
            // pre-edge value, which is what turns sync1/sync2 into a chain.
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;   // only the falling (pressed) transition
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_fpga_seq.sv
// -----------------------------------------------------------------------------
// alu_fpga_seq
// Board harness between DE2 pins and one ALU. Debounces KEY[3:0], loads the
// operands from the slide switches in half-word steps, sequences one ALU op
// per K2 press, registers result and flags, and drives a paged hex display.
//
// Ports
//   CLK, nRST                 clock / asynchronous active-low reset
//   key_n[3:0]                raw push-buttons (K0 load A, K1 load B,
//                             K2 execute, K3 next display page)
//   sw[17:0]                  slide switches (operand data, opcode)
//   aluop, porta, portb       drive the ALU
//   alu_out, alu_neg/ovf/zero ALU result and flags (combinational)
//   hex[NUM_DIGITS]           active-low 7-seg digits, hex[0] = LS digit
//   ledr[17:0]                status LEDs
// -----------------------------------------------------------------------------
module alu_fpga_seq
    import cpu_types_pkg::*;
    import fpga_disp_pkg::*;
#(
    parameter int  WORD_W          = 32,
    parameter int  DEBOUNCE_CYCLES = 500000,
    parameter int  BLANK_LZ        = 0,
    localparam int NUM_DIGITS      = WORD_W / 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [3:0]                 key_n,
    input  logic [17:0]                sw,
    output aluop_t                     aluop,
    output logic [WORD_W-1:0]          porta,
    output logic [WORD_W-1:0]          portb,
    input  logic [WORD_W-1:0]          alu_out,
    input  logic                       alu_neg,
    input  logic                       alu_ovf,
    input  logic                       alu_zero,
    output logic [NUM_DIGITS-1:0][6:0] hex,
    output logic [17:0]                ledr
);

    logic [3:0]        press;
    logic              k0, k1, k2, k3;
    seq_state_t        state, state_nxt;
    page_t             page;
    logic [WORD_W-1:0] result;
    logic              a_vld, b_vld, err;
    logic              neg_q, ovf_q, zero_q;
    logic              do_load_a, do_load_b, do_exec, do_err;
    logic              busy;

    // ---------------- key inputs ----------------
    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .CLK   (CLK),
            .nRST  (nRST),
            .key_n (key_n[k]),
            .press (press[k])
        );
    end

    // Simultaneous pulses: lowest key number wins, the rest are dropped.
    assign k0 = press[0];
    assign k1 = press[1] & ~press[0];
    assign k2 = press[2] & ~(|press[1:0]);
    assign k3 = press[3] & ~(|press[2:0]);

    // Switch-to-operand mapping. sw[17]=0 loads a sign-extended 17-bit value
    // (sw[16] is the sign); sw[17]=1 replaces bits 31:16 and keeps the low
    // half, with any bits above 31 following sw[15].
    function automatic logic [WORD_W-1:0] load_value(input logic [WORD_W-1:0] cur,
                                                     input logic [17:0]       s);
        logic [WORD_W-1:0] v;
        logic [15:0]       hi;
        v  = cur;
        hi = s[15:0];
        if (!s[17]) begin
            v[15:0] = s[15:0];
            for (int i = 16; i < WORD_W; i++) v[i] = s[16];
        end else begin
            for (int i = 16; i < WORD_W; i++) v[i] = (i < 32) ? hi[i % 16] : hi[15];
        end
        return v;
    endfunction

    // ---------------- sequencer ----------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        do_load_a = 1'b0;
        do_load_b = 1'b0;
        do_exec   = 1'b0;
        do_err    = 1'b0;
        unique case (state)
            IDLE, SHOW: begin
                if (k0) begin
                    do_load_a = 1'b1;
                    state_nxt = IDLE;
                end else if (k1) begin
                    do_load_b = 1'b1;
                    state_nxt = IDLE;
                end else if (k2) begin
                    if (a_vld && b_vld) begin
                        do_exec   = 1'b1;
                        state_nxt = EXEC;
                    end else begin
                        do_err = 1'b1;
                    end
                end
            end
            EXEC:    state_nxt = LATCH;   // ALU output settles this cycle
            LATCH:   state_nxt = SHOW;    // result captured at end of this cycle
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            porta  <= '0;
            portb  <= '0;
            result <= '0;
            aluop  <= ALU_SLL;            // encoding 4'h0
            a_vld  <= 1'b0;
            b_vld  <= 1'b0;
            err    <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            page   <= RESULT;
        end else begin
            if (do_load_a) begin
                porta <= load_value(porta, sw);
                a_vld <= 1'b1;
            end
            if (do_load_b) begin
                portb <= load_value(portb, sw);
                b_vld <= 1'b1;
            end
            if (do_exec) begin
                aluop <= aluop_t'(sw[3:0]);
                err   <= 1'b0;
            end else if (do_err) begin
                err <= 1'b1;              // sticky until a good execute
            end
            if (state == LATCH) begin
                result <= alu_out;
                neg_q  <= alu_neg;
                ovf_q  <= alu_ovf;
                zero_q <= alu_zero;
            end
            if (k3) page <= page_t'(page + 2'd1);
        end
    end

    // ---------------- display ----------------
    logic [NUM_DIGITS-1:0][6:0] disp_nxt;
    logic [WORD_W-1:0]          disp_val;
    logic                       lead;      // still inside leading zeros

    always_comb begin
        disp_nxt = {NUM_DIGITS{SEG_BLANK}};
        lead     = 1'b1;
        case (page)
            OPA:     disp_val = porta;
            OPB:     disp_val = portb;
            default: disp_val = result;
        endcase
        if (page == STATUS) begin
            disp_nxt[0] = hex2seg(aluop);
            disp_nxt[1] = hex2seg({1'b0, neg_q, ovf_q, zero_q});
        end else begin
            // Walk from the most significant digit so 'lead' drops at the
            // first non-zero nibble; digit 0 is always lit.
            for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                if (disp_val[4*i +: 4] != 4'h0) lead = 1'b0;
                if ((BLANK_LZ != 0) && lead && (i != 0)) disp_nxt[i] = SEG_BLANK;
                else                                     disp_nxt[i] = hex2seg(disp_val[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                hex[i] <= ((BLANK_LZ != 0) && (i != 0)) ? SEG_BLANK : hex2seg(4'h0);
        end else begin
            hex <= disp_nxt;
        end
    end

    // ---------------- status LEDs ----------------
    assign busy = (state == EXEC) || (state == LATCH);
    assign ledr = {7'b0, aluop, zero_q, ovf_q, neg_q, err, busy, b_vld, a_vld};

endmodule
